// File: rtl/ir_move_scheduler.sv
// rtl/ir_move_scheduler.sv - queues IR direction commands and applies one per video frame
//
// Purpose: sits between the RC-5 command decoder and the sprite renderer. Decoded
//   direction commands go into a small FIFO. At most one is applied per FrameTick,
//   and each applied command moves a clamped sprite position by STEP pixels.
// Ports:
//   Clock, Reset (async, active-high)
//   CmdValid, Up, Down, Left, Right : decoder strobe plus direction levels
//   FrameTick : start-of-vertical-blanking strobe
//   PosX, PosY : sprite position
//   Moving : high the cycle PosX/PosY change
//   Overflow : command dropped because the FIFO is full
//   Pending : FIFO occupancy
// Optional feature: define IR_MOVE_REPEAT_EN to auto-repeat the last applied direction
//   for REPEAT_N frames once the FIFO runs dry.
module ir_move_scheduler #(
    parameter int DEPTH    = 4,
    parameter int STEP     = 8,
    parameter int MAX_X    = 632,
    parameter int MAX_Y    = 472,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240,
    parameter int REPEAT_N = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       FrameTick,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       Moving,
    output logic       Overflow,
    output logic [2:0] Pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic [9:0] STEP_W  = 10'(STEP);
    localparam logic [9:0] MAX_X_W = 10'(MAX_X);
    localparam logic [9:0] MAX_Y_W = 10'(MAX_Y);

    logic [1:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;

    logic [3:0]    dir_bits;
    logic [1:0]    dir_enc;
    logic [1:0]    head;
    logic          push_req;
    logic          full;
    logic          pop;
    logic          push_acc;
    logic          apply_go;
    logic [1:0]    apply_dir;

    function automatic logic [9:0] dec_sat(input logic [9:0] p);
        return (p < STEP_W) ? 10'd0 : p - STEP_W;
    endfunction

    // Sum is formed one bit wider so the clamp is decided before any wrap could occur.
    function automatic logic [9:0] inc_sat(input logic [9:0] p, input logic [9:0] lim);
        logic [10:0] s;
        s = {1'b0, p} + {1'b0, STEP_W};
        return (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction

    assign dir_bits = {Right, Left, Down, Up};
    assign push_req = CmdValid & $onehot(dir_bits);
    assign full     = (count == CW'(DEPTH));
    assign pop      = FrameTick & (state == S_IDLE) & (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_acc = push_req & (~full | pop);
    assign Overflow = push_req & full & ~pop;
    assign head     = fifo_mem[rd_ptr];
    assign Pending  = 3'(count);

    always_comb begin
        dir_enc = D_UP;
        if (Down)       dir_enc = D_DOWN;
        else if (Left)  dir_enc = D_LEFT;
        else if (Right) dir_enc = D_RIGHT;
    end

`ifdef IR_MOVE_REPEAT_EN
    logic [3:0] rep_cnt;
    logic [1:0] last_dir;
    logic       rep_go;

    assign rep_go = FrameTick & (state == S_IDLE) & (count == '0) & (rep_cnt != 4'd0);

    always_comb begin
        apply_go  = pop | rep_go;
        apply_dir = pop ? head : last_dir;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rep_cnt  <= 4'd0;
            last_dir <= D_UP;
        end else begin
            // A fresh command from the remote cancels any auto-repeat in progress.
            if (push_req)    rep_cnt <= 4'd0;
            else if (pop)    rep_cnt <= 4'(REPEAT_N);
            else if (rep_go) rep_cnt <= rep_cnt - 4'd1;
            if (pop) last_dir <= head;
        end
    end
`else
    always_comb begin
        apply_go  = pop;
        apply_dir = head;
    end
`endif

    always_ff @(posedge Clock) begin
        if (push_acc) fifo_mem[wr_ptr] <= dir_enc;
    end

    // Position is written on the pop edge so it is already valid in the APPLY cycle,
    // which is the cycle Moving is high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
            PosX   <= 10'(INIT_X);
            PosY   <= 10'(INIT_Y);
            Moving <= 1'b0;
        end else begin
            Moving <= apply_go;
            state  <= apply_go ? S_APPLY : S_IDLE;
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_acc) - CW'(pop);
            if (apply_go) begin
                case (apply_dir)
                    D_UP:    PosY <= dec_sat(PosY);
                    D_DOWN:  PosY <= inc_sat(PosY, MAX_Y_W);
                    D_LEFT:  PosX <= dec_sat(PosX);
                    default: PosX <= inc_sat(PosX, MAX_X_W);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_move_scheduler.sv
// tb/tb_ir_move_scheduler.sv - scoreboard bench for ir_move_scheduler
module tb_ir_move_scheduler;

    localparam int DEPTH    = 4;
    localparam int STEP     = 8;
    localparam int MAX_X    = 632;
    localparam int MAX_Y    = 472;
    localparam int INIT_X   = 320;
    localparam int INIT_Y   = 240;
    localparam int REPEAT_N = 15;

    logic       Clock;
    logic       Reset;
    logic       CmdValid;
    logic       Up;
    logic       Down;
    logic       Left;
    logic       Right;
    logic       FrameTick;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic       Moving;
    logic       Overflow;
    logic [2:0] Pending;

    ir_move_scheduler #(
        .DEPTH(DEPTH), .STEP(STEP), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .REPEAT_N(REPEAT_N)
    ) dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .FrameTick(FrameTick), .PosX(PosX), .PosY(PosY),
        .Moving(Moving), .Overflow(Overflow), .Pending(Pending)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int x;
        int y;
    } pos_t;

    int   n_checks = 0;
    int   n_fail   = 0;

    pos_t exp_moves[$];
    int   exp_ovf[$];

    int   mq[$];
    int   mx, my;
    bit   mbusy;
    int   mrep, mlast;

    localparam bit [3:0] B_UP    = 4'b0001;
    localparam bit [3:0] B_DOWN  = 4'b0010;
    localparam bit [3:0] B_LEFT  = 4'b0100;
    localparam bit [3:0] B_RIGHT = 4'b1000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Direction codes: 0 up, 1 down, 2 left, 3 right.
    task automatic model_apply(input int d);
        pos_t p;
        case (d)
            0: my = (my < STEP) ? 0 : my - STEP;
            1: my = (my + STEP > MAX_Y) ? MAX_Y : my + STEP;
            2: mx = (mx < STEP) ? 0 : mx - STEP;
            default: mx = (mx + STEP > MAX_X) ? MAX_X : mx + STEP;
        endcase
        p.x = mx;
        p.y = my;
        exp_moves.push_back(p);
    endtask

    task automatic model_step(input bit cv, input bit [3:0] dirs, input bit tick);
        int  pre;
        bit  pop;
        bit  full;
        bit  applied;
        int  d;
        pre     = mq.size();
        full    = (pre == DEPTH);
        pop     = tick && !mbusy && pre > 0;
        applied = 0;
        if (pop) begin
            d = mq.pop_front();
            model_apply(d);
            applied = 1;
            mrep  = REPEAT_N;
            mlast = d;
        end
`ifdef IR_MOVE_REPEAT_EN
        else if (tick && !mbusy && pre == 0 && mrep > 0) begin
            model_apply(mlast);
            applied = 1;
            mrep--;
        end
`endif
        mbusy = applied;
        if (cv && $countones(dirs) == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (dirs[i]) d = i;
            if (!full || pop) mq.push_back(d);
            else exp_ovf.push_back(DEPTH);
            mrep = 0;
        end
    endtask

    // Inputs are held for exactly one rising edge; Pending at this point reflects
    // everything the model has seen so far.
    task automatic step(input bit cv, input bit [3:0] dirs, input bit tick);
        @(posedge Clock);
        #1;
        check("pending", int'(Pending), mq.size());
        CmdValid  = cv;
        {Right, Left, Down, Up} = dirs;
        FrameTick = tick;
        model_step(cv, dirs, tick);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'b0000, 0);
    endtask

    task automatic cmd(input bit [3:0] dirs);
        step(1, dirs, 0);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 0);
    endtask

    task automatic check_drained();
        check("moves_outstanding", exp_moves.size(), 0);
        check("overflows_outstanding", exp_ovf.size(), 0);
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        CmdValid  = 1'b0;
        {Right, Left, Down, Up} = 4'b0000;
        FrameTick = 1'b0;
        #1;
        check("reset_posx", int'(PosX), INIT_X);
        check("reset_posy", int'(PosY), INIT_Y);
        check("reset_pending", int'(Pending), 0);
        check("reset_moving", int'(Moving), 0);
        check("reset_overflow", int'(Overflow), 0);
        mq.delete();
        exp_moves.delete();
        exp_ovf.delete();
        mx    = INIT_X;
        my    = INIT_Y;
        mbusy = 0;
        mrep  = 0;
        mlast = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    always @(negedge Clock) begin
        if (!Reset) begin
            if (Moving) begin
                if (exp_moves.size() == 0) begin
                    check("unexpected_move", 1, 0);
                end else begin
                    pos_t e;
                    e = exp_moves.pop_front();
                    check("move_posx", int'(PosX), e.x);
                    check("move_posy", int'(PosY), e.y);
                end
            end
            if (Overflow) begin
                if (exp_ovf.size() == 0) begin
                    check("unexpected_overflow", 1, 0);
                end else begin
                    int e;
                    e = exp_ovf.pop_front();
                    check("overflow_pending", int'(Pending), e);
                end
            end
        end
    end

    initial begin
        CmdValid  = 1'b0;
        {Right, Left, Down, Up} = 4'b0000;
        FrameTick = 1'b0;
        Reset     = 1'b0;
        #2;
        do_reset();

        // single Right command, one-cycle latency
        step(1, B_RIGHT, 0);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 0);
        check("t1_posx", int'(PosX), 328);
        check("t1_posy", int'(PosY), 240);
        check("t1_moving", int'(Moving), 1);
        check("t1_pending", int'(Pending), 0);
        idle(2);
        check_drained();

        // saturation at the top and bottom edges
        for (int i = 0; i < 31; i++) cmd(B_UP);
        check("t2_top", int'(PosY), 0);
        for (int i = 0; i < 60; i++) cmd(B_DOWN);
        check("t2_bottom", int'(PosY), MAX_Y);
        idle(2);
        check_drained();

        // overflow on the fifth push, then in-order drain
        do_reset();
        step(1, B_RIGHT, 0);
        step(1, B_DOWN, 0);
        step(1, B_LEFT, 0);
        step(1, B_DOWN, 0);
        step(1, B_UP, 0);
        #1;
        check("t3_overflow", int'(Overflow), 1);
        idle(1);
        check("t3_full", int'(Pending), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0000, 1);
            step(0, 4'b0000, 0);
        end
        idle(2);
        check("t3_posx", int'(PosX), 320);
        check("t3_posy", int'(PosY), 256);
        check_drained();

        // full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) step(1, B_LEFT, 0);
        step(1, B_UP, 1);
        #1;
        check("t4_no_overflow", int'(Overflow), 0);
        idle(1);
        check("t4_pending", int'(Pending), 4);
        check("t4_posx", int'(PosX), 312);
        idle(2);
        check_drained();

        // malformed commands, then reset in the APPLY cycle
        do_reset();
        step(1, B_UP | B_LEFT, 0);
        step(1, 4'b0000, 0);
        step(0, 4'b0000, 1);
        idle(2);
        check("t5_ignored", int'(Pending), 0);
        check_drained();
        step(1, B_RIGHT, 0);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 0);
        check("t5_moving_before_reset", int'(Moving), 1);
        do_reset();
        idle(2);

`ifdef IR_MOVE_REPEAT_EN
        step(1, B_LEFT, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 4'b0000, 1);
            step(0, 4'b0000, 0);
        end
        idle(2);
        check("t6_repeat_posx", int'(PosX), 192);
        check_drained();
        do_reset();
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            bit       cv;
            bit [3:0] dirs;
            bit       tick;
            cv   = ($urandom_range(0, 2) == 0);
            dirs = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3))
                                               : 4'($urandom_range(0, 15));
            tick = ($urandom_range(0, 2) == 0);
            step(cv, dirs, tick);
        end
        idle(3);
        check("rand_posx", int'(PosX), mx);
        check("rand_posy", int'(PosY), my);
        check_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
